// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit buffer: byte width and the
// drain state machine encoding.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SENT = 2'b01,
    ST_BUSY = 2'b10
  } drain_state_t;

  // Next value of a wrapping pointer. The extra MSB separates full from empty.
  function automatic logic [7:0] ptr_inc8(input logic [7:0] ptr);
    return ptr + 8'd1;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte storage for the transmit buffer. Holds the array, the read and write
// pointers, the full/empty/level decode, the sticky overflow flag and flush.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [BYTE_W-1:0]        wr_data,
  input  logic                     flush,
  input  logic                     pop,
  output logic [BYTE_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              overflow_r;
  logic              push_ok_s;
  logic              pop_ok_s;
  logic [AW:0]       ptr_one_s;

  assign ptr_one_s = {{AW{1'b0}}, 1'b1};

  // Status decode straight from the registered pointers.
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign level   = wr_ptr_r - rd_ptr_r;
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
  assign overflow = overflow_r;

  // A push is taken only when there is room; a pop never frees room for a
  // push in the same cycle, so a write while full is always dropped.
  assign push_ok_s = wr_en && !full && !flush;
  assign pop_ok_s  = pop && !empty && !flush;

  // Array write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Write and read pointers, cleared by reset or flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ptr_one_s;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_one_s;
      end
    end
  end

  // Sticky overflow: set by a push attempt while full, cleared by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (flush) begin
      overflow_r <= 1'b0;
    end else if (wr_en && full) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-side byte buffer in front of the UART transmitter. Bytes pushed by
// the host are queued in uart_sync_fifo and handed one at a time to the
// transmitter with a tx_enable pulse, pacing on tx_busy.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [BYTE_W-1:0]        wr_data,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     tx_busy,
  output logic                     tx_enable,
  output logic [BYTE_W-1:0]        tx_data
);

  drain_state_t      state_r;
  drain_state_t      state_next_s;
  logic              issue_s;
  logic [BYTE_W-1:0] head_data_s;
  logic              tx_enable_r;
  logic [BYTE_W-1:0] tx_data_r;

  uart_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .pop      (issue_s),
    .rd_data  (head_data_s),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  // Drain state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and issue decode. A flush cycle never issues, so the state
  // machine is unaffected by a flush and an in-flight character completes.
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty && !tx_busy && !flush) begin
          issue_s      = 1'b1;
          state_next_s = ST_SENT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SENT: begin
        if (tx_busy) begin
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_SENT;
        end
      end
      ST_BUSY: begin
        if (!tx_busy) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Registered handshake towards the transmitter; tx_data holds between issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_enable_r <= 1'b0;
      tx_data_r   <= 8'h00;
    end else begin
      tx_enable_r <= issue_s;
      if (issue_s) begin
        tx_data_r <= head_data_s;
      end else begin
        tx_data_r <= tx_data_r;
      end
    end
  end

  assign tx_enable = tx_enable_r;
  assign tx_data   = tx_data_r;

endmodule
